// File: rtl/ikbd_link_buffer_pkg.sv
// Shared types for the ikbd link buffer: byte type, default sizes, presenter states.
package ikbd_link_buffer_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEPTH_LOG2_DEFAULT  = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } pres_state_t;

endpackage

// File: rtl/ikbd_link_buffer_sync_byte_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers; head is read combinationally.
module sync_byte_fifo
  import ikbd_link_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  byte_t i_din,
  input  logic  i_pop,
  output byte_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  byte_t               r_mem [DEPTH];
  logic                w_push_ok;
  logic                w_pop_ok;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);

  // A pop on empty is dropped; a push on full succeeds only if a pop frees the slot.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_dout    = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= {(DEPTH_LOG2+1){1'b0}};
      r_rptr <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rptr <= r_rptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_din;
  end

endmodule

// File: rtl/ikbd_link_buffer.sv
// Buffers ikbd bytes between the SPI io-controller link and the ACIA, with input
// synchronisers, an RX FIFO and a TX FIFO feeding a transaction-safe presenter.
module ikbd_link_buffer
  import ikbd_link_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ss,
  input  logic       link_strobe_in,
  input  logic [7:0] link_data_in,
  input  logic       link_strobe_out,
  output logic       link_data_out_available,
  output logic [7:0] link_data_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_full,
  output logic       rx_overrun
);

  // Synchroniser lanes packed as {spi_ss, strobe_out, strobe_in}; spi_ss idles high.
  localparam logic [2:0] SYNC_RESET = 3'b100;

  logic [2:0]  r_sync [SYNC_STAGES];
  logic [1:0]  r_prev;
  logic [2:0]  w_sync;
  logic        w_sin_edge;
  logic        w_sout_edge;
  logic        w_ss;

  logic        r_rx_push;
  byte_t       r_rx_byte;
  logic        r_rx_overrun;
  logic        w_rx_full;
  logic        w_rx_empty;

  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_tx_pop;
  byte_t       w_tx_head;

  pres_state_t r_state;
  pres_state_t w_state_next;
  logic        w_load;
  logic        r_avail;
  byte_t       r_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RESET;
      r_prev <= 2'b00;
    end else begin
      r_sync[0] <= {spi_ss, link_strobe_out, link_strobe_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync[1:0];
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_sin_edge  = w_sync[0] & ~r_prev[0];
  assign w_sout_edge = w_sync[1] & ~r_prev[1];
  assign w_ss        = w_sync[2];

  // Byte is captured on the edge cycle and pushed on the following one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_push    <= 1'b0;
      r_rx_byte    <= 8'h00;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_push    <= w_sin_edge;
      r_rx_byte    <= w_sin_edge ? link_data_in : r_rx_byte;
      r_rx_overrun <= r_rx_push & w_rx_full & ~rx_read;
    end
  end

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_rx_push),
    .i_din   (r_rx_byte),
    .i_pop   (rx_read),
    .o_dout  (rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign rx_valid   = ~w_rx_empty;
  assign rx_overrun = r_rx_overrun;

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (tx_write & ~w_tx_full),
    .i_din   (tx_data),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign tx_full = w_tx_full;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Loading only while the slave select is idle keeps the pair frozen mid-transaction.
  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss && !w_tx_empty) begin
          w_state_next = ST_PRESENT;
          w_tx_pop     = 1'b1;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (w_sout_edge) w_state_next = ST_IDLE;
        else             w_state_next = ST_PRESENT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_avail    <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      r_avail    <= (w_state_next == ST_PRESENT);
      r_data_out <= w_load ? w_tx_head : r_data_out;
    end
  end

  assign link_data_out_available = r_avail;
  assign link_data_out           = r_data_out;

endmodule

// File: tb/tb_ikbd_link_buffer.sv
// Scoreboard bench for ikbd_link_buffer: queue-based reference model, negedge monitor.
module tb_ikbd_link_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_ss = 1'b1;
  logic       link_strobe_in = 1'b0;
  logic [7:0] link_data_in = 8'h00;
  logic       link_strobe_out = 1'b0;
  logic       link_data_out_available;
  logic [7:0] link_data_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_full;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int ov_seen = 0;
  int exp_ov = 0;
  logic prev_avail = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  localparam int CAP = 16;

  ikbd_link_buffer dut (
    .clk                     (clk),
    .reset                   (reset),
    .spi_ss                  (spi_ss),
    .link_strobe_in          (link_strobe_in),
    .link_data_in            (link_data_in),
    .link_strobe_out         (link_strobe_out),
    .link_data_out_available (link_data_out_available),
    .link_data_out           (link_data_out),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid),
    .rx_read                 (rx_read),
    .tx_data                 (tx_data),
    .tx_write                (tx_write),
    .tx_full                 (tx_full),
    .rx_overrun              (rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: scores RX pops, newly presented TX bytes and overrun pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_overrun) ov_seen++;
      if (rx_read && rx_q.size() > 0) begin
        check("rx_valid_on_read", 32'(rx_valid), 32'd1);
        check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
      if (link_data_out_available && !prev_avail) begin
        if (tx_q.size() > 0) begin
          check("tx_presented", 32'(link_data_out), 32'(tx_q.pop_front()));
        end else begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_present actual=%0h expected=none", link_data_out);
        end
      end
    end
    prev_avail = link_data_out_available;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit chk_lat);
    @(posedge clk); #1;
    link_data_in   = b;
    link_strobe_in = 1'b1;
    if (rx_q.size() < CAP) rx_q.push_back(b);
    else exp_ov++;
    if (chk_lat) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rx_latency_early", 32'(rx_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rx_latency_on_time", 32'(rx_valid), 32'd1);
    end else begin
      repeat (4) @(posedge clk);
    end
    cyc(2);
    link_strobe_in = 1'b0;
    cyc(4);
  endtask

  task automatic read_rx(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_read = 1'b1;
      @(posedge clk); #1;
      rx_read = 1'b0;
    end
    cyc(2);
  endtask

  task automatic write_tx(input logic [7:0] b);
    @(posedge clk); #1;
    tx_data  = b;
    tx_write = 1'b1;
    if (tx_q.size() < CAP) tx_q.push_back(b);
    @(posedge clk); #1;
    tx_write = 1'b0;
  endtask

  task automatic strobe_out_pulse();
    cyc(3);
    link_strobe_out = 1'b1;
    cyc(4);
    link_strobe_out = 1'b0;
    cyc(4);
  endtask

  // Present one pending byte, then end the transaction with spi_ss low.
  task automatic consume();
    @(posedge clk); #1;
    spi_ss = 1'b1;
    cyc(5);
    @(negedge clk);
    check("tx_avail_present", 32'(link_data_out_available), 32'd1);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    strobe_out_pulse();
    @(negedge clk);
    check("tx_avail_after_strobe", 32'(link_data_out_available), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_tx_full", 32'(tx_full), 32'd0);
    check("reset_overrun", 32'(rx_overrun), 32'd0);
    check("reset_avail", 32'(link_data_out_available), 32'd0);
    check("reset_data_out", 32'(link_data_out), 32'd0);

    // RX basic
    send_rx(8'h1C, 1'b1);
    send_rx(8'h9C, 1'b0);
    send_rx(8'h39, 1'b0);
    read_rx(3);
    @(negedge clk);
    check("rx_empty_after_basic", 32'(rx_valid), 32'd0);

    // RX random rounds
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_rx(b, 1'b0);
      end
      read_rx(n);
      @(negedge clk);
      check("rx_empty_after_round", 32'(rx_valid), 32'd0);
    end

    // RX overflow: 17 strobes, no reads
    ov_seen = 0;
    exp_ov  = 0;
    for (int i = 0; i < CAP + 1; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b0);
    end
    check("rx_overrun_count", 32'(ov_seen), 32'(exp_ov));
    check("rx_model_count", 32'(rx_q.size()), 32'd16);
    read_rx(CAP);
    @(negedge clk);
    check("rx_empty_after_overflow", 32'(rx_valid), 32'd0);

    // TX present/pop
    write_tx(8'hF1);
    write_tx(8'hF2);
    cyc(5);
    @(negedge clk);
    check("tx_first_avail", 32'(link_data_out_available), 32'd1);
    check("tx_first_data", 32'(link_data_out), 32'hF1);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    strobe_out_pulse();
    @(negedge clk);
    check("tx_avail_dropped", 32'(link_data_out_available), 32'd0);
    check("tx_data_retained", 32'(link_data_out), 32'hF1);
    @(posedge clk); #1;
    spi_ss = 1'b1;
    cyc(5);
    @(negedge clk);
    check("tx_second_avail", 32'(link_data_out_available), 32'd1);
    check("tx_second_data", 32'(link_data_out), 32'hF2);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    strobe_out_pulse();

    // TX fill to full with spi_ss low, extra writes ignored
    for (int i = 0; i < CAP + 4; i++) begin
      b = 8'($urandom);
      write_tx(b);
    end
    @(negedge clk);
    check("tx_full_flag", 32'(tx_full), 32'(tx_q.size() == CAP));
    check("tx_frozen_while_ss_low", 32'(link_data_out_available), 32'd0);
    for (int i = 0; i < CAP; i++) consume();
    @(posedge clk); #1;
    spi_ss = 1'b1;
    cyc(5);
    @(negedge clk);
    check("tx_no_extra_byte", 32'(link_data_out_available), 32'd0);
    check("tx_not_full", 32'(tx_full), 32'd0);

    // TX freeze timing
    @(posedge clk); #1;
    spi_ss = 1'b0;
    cyc(4);
    write_tx(8'h55);
    cyc(6);
    @(negedge clk);
    check("tx_freeze_hold", 32'(link_data_out_available), 32'd0);
    @(posedge clk); #1;
    spi_ss = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("tx_freeze_early", 32'(link_data_out_available), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tx_freeze_release", 32'(link_data_out_available), 32'd1);
    check("tx_freeze_data", 32'(link_data_out), 32'h55);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    strobe_out_pulse();

    // Spurious strobe_out in IDLE with an empty FIFO
    @(posedge clk); #1;
    spi_ss = 1'b1;
    strobe_out_pulse();
    @(negedge clk);
    check("spurious_avail", 32'(link_data_out_available), 32'd0);
    write_tx(8'h77);
    cyc(5);
    @(negedge clk);
    check("spurious_then_avail", 32'(link_data_out_available), 32'd1);
    check("spurious_then_data", 32'(link_data_out), 32'h77);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    strobe_out_pulse();

    // Reset mid-operation
    @(posedge clk); #1;
    spi_ss = 1'b1;
    for (int i = 0; i < 4; i++) write_tx(8'($urandom));
    for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'b0);
    @(negedge clk);
    check("pre_reset_avail", 32'(link_data_out_available), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete();
    tx_q.delete();
    @(negedge clk);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_tx_full", 32'(tx_full), 32'd0);
    check("midreset_avail", 32'(link_data_out_available), 32'd0);
    check("midreset_data_out", 32'(link_data_out), 32'd0);
    check("midreset_overrun", 32'(rx_overrun), 32'd0);
    cyc(6);
    @(negedge clk);
    check("post_reset_tx_empty", 32'(link_data_out_available), 32'd0);
    send_rx(8'hAA, 1'b0);
    @(negedge clk);
    check("post_reset_rx_valid", 32'(rx_valid), 32'd1);
    check("post_reset_rx_data", 32'(rx_data), 32'hAA);
    read_rx(1);
    @(negedge clk);
    check("post_reset_sole_entry", 32'(rx_valid), 32'd0);
    check("scoreboard_drained", 32'(rx_q.size() + tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
